// File: rtl/defender_pkg.sv
// defender_pkg: game selects, PS/2 scan codes and coin FSM states for arcade_input_mapper.
package defender_pkg;
   localparam logic [7:0] MOD_DEFENDER = 8'd0;
   localparam logic [7:0] MOD_COLONY7  = 8'd1;
   localparam logic [7:0] MOD_MAYDAY   = 8'd2;
   localparam logic [7:0] MOD_JIN      = 8'd3;

   localparam logic [7:0] SC_UP = 8'h75, SC_DOWN = 8'h72, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_COIN1 = 8'h76, SC_COIN1_ALT = 8'h2E, SC_COIN2 = 8'h36;
   localparam logic [7:0] SC_START1 = 8'h05, SC_START1_ALT = 8'h16;
   localparam logic [7:0] SC_START2 = 8'h06, SC_START2_ALT = 8'h1E;
   localparam logic [7:0] SC_FIRE_A = 8'h14, SC_FIRE_B = 8'h11, SC_FIRE_C = 8'h29, SC_FIRE_D = 8'h12;
   localparam logic [7:0] SC_P2_UP = 8'h2D, SC_P2_DOWN = 8'h2B, SC_P2_LEFT = 8'h23, SC_P2_RIGHT = 8'h34;
   localparam logic [7:0] SC_FIRE2_A = 8'h1C, SC_FIRE2_B = 8'h1B, SC_FIRE2_C = 8'h21, SC_FIRE2_D = 8'h1D;

   localparam int         NUM_KEYS = 20;
   localparam logic [4:0] KEY_NONE = 5'd31;

   typedef enum logic [1:0] {COIN_IDLE, COIN_PULSE, COIN_HOLD, COIN_WAIT_REL} coin_state_t;

   // Latch slots 7:0 and 19:12 follow the joystick word order R,L,D,U,F1..F4 so they OR directly.
   function automatic logic [4:0] key_index(input logic [7:0] code);
      case (code)
         SC_RIGHT:                 return 5'd0;
         SC_LEFT:                  return 5'd1;
         SC_DOWN:                  return 5'd2;
         SC_UP:                    return 5'd3;
         SC_FIRE_A:                return 5'd4;
         SC_FIRE_B:                return 5'd5;
         SC_FIRE_C:                return 5'd6;
         SC_FIRE_D:                return 5'd7;
         SC_COIN1, SC_COIN1_ALT:   return 5'd8;
         SC_COIN2:                 return 5'd9;
         SC_START1, SC_START1_ALT: return 5'd10;
         SC_START2, SC_START2_ALT: return 5'd11;
         SC_P2_RIGHT:              return 5'd12;
         SC_P2_LEFT:               return 5'd13;
         SC_P2_DOWN:               return 5'd14;
         SC_P2_UP:                 return 5'd15;
         SC_FIRE2_A:               return 5'd16;
         SC_FIRE2_B:               return 5'd17;
         SC_FIRE2_C:               return 5'd18;
         SC_FIRE2_D:               return 5'd19;
         default:                  return KEY_NONE;
      endcase
   endfunction
endpackage

// File: rtl/coin_shaper.sv
// coin_shaper: turns the raw coin source into a pulse of at least COIN_MIN_CYC and at most
// COIN_MAX_CYC cycles; a held source is cut off and must be released before the next coin.
module coin_shaper
   import defender_pkg::*;
#(
   parameter int COIN_MIN_CYC = 2400000,
   parameter int COIN_MAX_CYC = 4800000
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic src,
   output logic coin
);
   localparam int            CW       = $clog2(COIN_MAX_CYC + 1);
   localparam logic [CW-1:0] MIN_LAST = CW'(COIN_MIN_CYC - 1);
   localparam logic [CW-1:0] MAX_LAST = CW'(COIN_MAX_CYC - 1);

   coin_state_t   r_state;
   logic [CW-1:0] r_cnt;
   logic          r_src_d;
   logic          r_coin;
   logic [CW-1:0] w_cnt_inc;

   assign w_cnt_inc = &r_cnt ? r_cnt : r_cnt + CW'(1);
   assign coin      = r_coin;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= COIN_IDLE;
         r_cnt   <= '0;
         r_src_d <= 1'b0;
         r_coin  <= 1'b0;
      end else begin
         r_src_d <= src;
         case (r_state)
            COIN_IDLE: if (src && !r_src_d) begin
               r_state <= COIN_PULSE;
               r_cnt   <= '0;
               r_coin  <= 1'b1;
            end
            COIN_PULSE: begin
               r_cnt <= w_cnt_inc;
               if (r_cnt >= MIN_LAST) begin
                  r_state <= src ? COIN_HOLD : COIN_IDLE;
                  r_coin  <= src;
               end
            end
            COIN_HOLD: begin
               r_cnt <= w_cnt_inc;
               if (!src) begin
                  r_state <= COIN_IDLE;
                  r_coin  <= 1'b0;
               end else if (r_cnt >= MAX_LAST) begin
                  r_state <= COIN_WAIT_REL;
                  r_coin  <= 1'b0;
               end
            end
            default: if (!src) r_state <= COIN_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: MiSTer keyboard/joystick to Williams in0/in1/in2 port bytes.
// Holds the keyboard button latches, merges sources and selects the per-game bit layout.
module arcade_input_mapper
   import defender_pkg::*;
#(
   parameter int COIN_MIN_CYC = 2400000,
   parameter int COIN_MAX_CYC = 4800000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic [31:0] joy1,
   input  logic [31:0] joy2,
   input  logic [7:0]  mod,
   input  logic [7:0]  dip0,
   input  logic [7:0]  dip1,
   input  logic [7:0]  dip2,
   output logic [7:0]  in0,
   output logic [7:0]  in1,
   output logic [7:0]  in2
);
   logic [NUM_KEYS-1:0] r_keys;
   logic                r_old_tgl;
   logic                r_primed;
   logic [4:0]          w_idx;
   logic [7:0]          w_g, w_in1, w_in2;
   logic                w_up, w_dn, w_lf, w_rt, w_fa, w_fb, w_fc, w_fd;
   logic                w_s1, w_s2, w_src, w_coin, w_unused;

   assign w_idx    = key_index(ps2_key[7:0]);
   assign w_g      = r_keys[7:0] | joy1[7:0] | r_keys[19:12] | joy2[7:0];
   assign {w_fd, w_fc, w_fb, w_fa, w_up, w_dn, w_lf, w_rt} = w_g;
   assign w_s1     = r_keys[10] | joy1[8] | joy2[8];
   assign w_s2     = r_keys[11] | joy1[9] | joy2[9];
   assign w_src    = r_keys[8] | r_keys[9] | joy1[10] | joy2[10];
   assign w_unused = &{1'b0, ps2_key[8], joy1[31:11], joy2[31:11]};

   always_comb begin
      w_in1 = '0;
      w_in2 = '0;
      case (mod)
         MOD_DEFENDER: begin
            w_in1 = {w_dn, w_lf | w_rt, w_s1, w_s2, w_fd, w_fc, w_fb, w_fa};
            w_in2 = {7'b0, w_up};
         end
         MOD_COLONY7: begin
            w_in1 = {w_fb, w_fa, w_s1, w_s2, w_up, w_lf, w_rt, w_dn};
            w_in2 = {7'b0, w_fc};
         end
         MOD_MAYDAY: begin
            w_in1 = {w_dn, 1'b0, w_s1, w_s2, w_fb, w_fc, w_rt, w_fa};
            w_in2 = {7'b0, w_up};
         end
         MOD_JIN: w_in1 = {w_fb, w_fa, w_s1, w_s2, w_rt, w_lf, w_dn, w_up};
         default: ;
      endcase
   end

   // The first edge after reset only samples the toggle, so a stale toggle level is not an event.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_keys    <= '0;
         r_old_tgl <= 1'b0;
         r_primed  <= 1'b0;
      end else begin
         r_old_tgl <= ps2_key[10];
         r_primed  <= 1'b1;
         if (r_primed && (ps2_key[10] != r_old_tgl) && (w_idx != KEY_NONE))
            r_keys[w_idx] <= ps2_key[9];
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         in0 <= '0;
         in1 <= '0;
         in2 <= '0;
      end else begin
         in0 <= dip0 | {3'b0, w_coin, 4'b0};
         in1 <= dip1 | w_in1;
         in2 <= dip2 | w_in2;
      end
   end

   coin_shaper #(
      .COIN_MIN_CYC(COIN_MIN_CYC),
      .COIN_MAX_CYC(COIN_MAX_CYC)
   ) u_coin (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .src    (w_src),
      .coin   (w_coin)
   );
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed and randomized checks of arcade_input_mapper against a
// name-keyed behavioural model of buttons, coin pulse age and game layouts.
module tb_arcade_input_mapper;
   localparam int MIN = 8, MAX = 20;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] ps2_key = '0;
   logic [31:0] joy1 = '0, joy2 = '0;
   logic [7:0]  mod = '0, dip0 = '0, dip1 = '0, dip2 = '0;
   logic [7:0]  in0, in1, in2;
   int          n_chk = 0, n_err = 0;

   arcade_input_mapper #(.COIN_MIN_CYC(MIN), .COIN_MAX_CYC(MAX)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy1(joy1), .joy2(joy2),
      .mod(mod), .dip0(dip0), .dip1(dip1), .dip2(dip2), .in0(in0), .in1(in1), .in2(in2)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   string names[20] = '{"R1", "L1", "D1", "U1", "FA1", "FB1", "FC1", "FD1", "COIN1", "COIN2",
                        "ST1", "ST2", "R2", "L2", "D2", "U2", "FA2", "FB2", "FC2", "FD2"};
   bit    kb[string];
   bit    m_tgl, m_primed, m_prev, m_act, m_wait;
   int    m_age;
   logic [7:0] e_in0, e_in1, e_in2;

   function automatic string name_of(input logic [7:0] c);
      case (c)
         8'h75: return "U1";    8'h72: return "D1";   8'h6B: return "L1";  8'h74: return "R1";
         8'h76, 8'h2E: return "COIN1";                8'h36: return "COIN2";
         8'h05, 8'h16: return "ST1";                  8'h06, 8'h1E: return "ST2";
         8'h14: return "FA1";   8'h11: return "FB1";  8'h29: return "FC1"; 8'h12: return "FD1";
         8'h2D: return "U2";    8'h2B: return "D2";   8'h23: return "L2";  8'h34: return "R2";
         8'h1C: return "FA2";   8'h1B: return "FB2";  8'h21: return "FC2"; 8'h1D: return "FD2";
         default: return "";
      endcase
   endfunction

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         foreach (names[i]) kb[names[i]] = 1'b0;
         m_tgl = 0; m_primed = 0; m_prev = 0; m_act = 0; m_wait = 0; m_age = 0;
         e_in0 = 0; e_in1 = 0; e_in2 = 0;
      end else begin
         bit u, d, l, r, fa, fb, fc, fd, s1, s2, src;
         string nm;
         u  = kb["U1"]  | kb["U2"]  | joy1[3] | joy2[3];
         d  = kb["D1"]  | kb["D2"]  | joy1[2] | joy2[2];
         l  = kb["L1"]  | kb["L2"]  | joy1[1] | joy2[1];
         r  = kb["R1"]  | kb["R2"]  | joy1[0] | joy2[0];
         fa = kb["FA1"] | kb["FA2"] | joy1[4] | joy2[4];
         fb = kb["FB1"] | kb["FB2"] | joy1[5] | joy2[5];
         fc = kb["FC1"] | kb["FC2"] | joy1[6] | joy2[6];
         fd = kb["FD1"] | kb["FD2"] | joy1[7] | joy2[7];
         s1 = kb["ST1"] | joy1[8] | joy2[8];
         s2 = kb["ST2"] | joy1[9] | joy2[9];
         src = kb["COIN1"] | kb["COIN2"] | joy1[10] | joy2[10];
         e_in0 = dip0 | (m_act ? 8'h10 : 8'h00);
         case (mod)
            8'd0: begin e_in1 = {d, l | r, s1, s2, fd, fc, fb, fa}; e_in2 = {7'b0, u};  end
            8'd1: begin e_in1 = {fb, fa, s1, s2, u, l, r, d};       e_in2 = {7'b0, fc}; end
            8'd2: begin e_in1 = {d, 1'b0, s1, s2, fb, fc, r, fa};   e_in2 = {7'b0, u};  end
            8'd3: begin e_in1 = {fb, fa, s1, s2, r, l, d, u};       e_in2 = 8'h00;      end
            default: begin e_in1 = 8'h00; e_in2 = 8'h00; end
         endcase
         e_in1 = e_in1 | dip1;
         e_in2 = e_in2 | dip2;
         nm = name_of(ps2_key[7:0]);
         if (m_primed && ps2_key[10] != m_tgl && nm != "") kb[nm] = ps2_key[9];
         m_tgl = ps2_key[10];
         m_primed = 1;
         // coin: age counts edges since the rise; kept for MIN edges, then while held up to MAX
         if (m_act) begin
            m_age++;
            if (m_age >= MIN && !src) m_act = 0;
            else if (m_age >= MAX) begin m_act = 0; m_wait = 1; end
         end else if (m_wait) begin
            if (!src) m_wait = 0;
         end else if (src && !m_prev) begin
            m_act = 1;
            m_age = 0;
         end
         m_prev = src;
      end
   end

   always @(negedge clk_sys) begin
      check("in0", in0, e_in0);
      check("in1", in1, e_in1);
      check("in2", in2, e_in2);
   end

   // ---------------- stimulus ----------------
   task automatic coin_run(input int hold, input int window, output int first, output int cnt);
      first = -1;
      cnt = 0;
      joy1[10] = 1'b1;
      for (int i = 1; i <= window; i++) begin
         if (i == hold + 1) joy1[10] = 1'b0;
         @(negedge clk_sys);
         if (in0 == 8'h10) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      joy1[10] = 1'b0;
   endtask

   logic [7:0] codes[24] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h76, 8'h2E, 8'h36, 8'h05, 8'h16, 8'h06,
                             8'h1E, 8'h14, 8'h11, 8'h29, 8'h12, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C,
                             8'h1B, 8'h21, 8'h1D, 8'h5A};

   initial begin
      int first, cnt;
      ps2_key = {1'b1, 1'b1, 1'b0, 8'h14};
      dip1 = 8'h20;
      repeat (3) @(negedge clk_sys);
      check("rst_in0", in0, 8'h00);
      check("rst_in1", in1, 8'h00);
      check("rst_in2", in2, 8'h00);
      reset_n = 1'b1;
      @(negedge clk_sys);
      check("prime_first_in1", in1, 8'h20);
      repeat (3) @(negedge clk_sys);
      check("prime_no_latch", in1, 8'h20);

      dip1 = 8'h00;
      ps2_key = {1'b0, 1'b1, 1'b0, 8'h14};
      @(negedge clk_sys);
      ps2_key = {1'b1, 1'b1, 1'b0, 8'h6B};
      repeat (2) @(negedge clk_sys);
      check("kbd_press", in1, 8'h41);
      ps2_key = {1'b0, 1'b0, 1'b0, 8'h6B};
      repeat (2) @(negedge clk_sys);
      check("kbd_release", in1, 8'h01);
      ps2_key = {1'b1, 1'b0, 1'b0, 8'h14};
      repeat (2) @(negedge clk_sys);
      check("kbd_clear", in1, 8'h00);

      mod = 8'd3;
      joy2 = 32'h30;
      @(negedge clk_sys);
      check("mod3_in1", in1, 8'hC0);
      check("mod3_in2", in2, 8'h00);
      mod = 8'd7;
      dip1 = 8'h5A;
      @(negedge clk_sys);
      check("mod7_in1", in1, 8'h5A);
      check("mod7_in2", in2, 8'h00);
      joy2 = '0; mod = 8'd0; dip1 = 8'h00;
      repeat (2) @(negedge clk_sys);

      coin_run(1, 20, first, cnt);
      check("coin1_start", first, 2);
      check("coin1_width", cnt, MIN);
      coin_run(100, 110, first, cnt);
      check("coin_held_width", cnt, MAX);
      check("coin_held_after", in0, 8'h00);
      coin_run(1, 20, first, cnt);
      check("coin_repress_width", cnt, MIN);

      joy1[10] = 1'b1;
      @(negedge clk_sys);
      joy1[10] = 1'b0;
      repeat (4) @(negedge clk_sys);
      check("coin_mid", in0, 8'h10);
      #2 reset_n = 1'b0;
      #1 check("rst_async_in0", in0, 8'h00);
      @(negedge clk_sys);
      reset_n = 1'b1;
      cnt = 0;
      repeat (15) begin
         @(negedge clk_sys);
         if (in0 == 8'h10) cnt++;
      end
      check("no_coin_after_rst", cnt, 0);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_sys);
         if ($urandom_range(0, 5) == 0) begin
            logic [7:0] code;
            code = ($urandom_range(0, 3) == 0) ? 8'($urandom) : codes[$urandom_range(0, 23)];
            ps2_key = {~ps2_key[10], 1'($urandom), 1'($urandom), code};
         end else if ($urandom_range(0, 7) == 0) ps2_key[9:0] = 10'($urandom);
         if ($urandom_range(0, 7) == 0) joy1 = $urandom & $urandom & $urandom;
         if ($urandom_range(0, 7) == 0) joy2 = $urandom & $urandom & $urandom;
         if ($urandom_range(0, 49) == 0)
            mod = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
         if ($urandom_range(0, 39) == 0) dip0 = 8'($urandom);
         if ($urandom_range(0, 39) == 0) dip1 = 8'($urandom);
         if ($urandom_range(0, 39) == 0) dip2 = 8'($urandom);
         if ($urandom_range(0, 799) == 0) begin
            #2 reset_n = 1'b0;
            @(negedge clk_sys);
            reset_n = 1'b1;
         end
      end
      @(negedge clk_sys);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
